scan_decoder: RTL

Parametrised N-to-2^N decoder with registered one-hot output and two modes: direct (decode a loaded select value) and scan (auto-advance through all outputs with programmable dwell). Drives strobe lines such as display digit selects, keypad row drives and time-multiplexed peripheral enables in the lab designs. It generalises the fixed 3-to-8 enable decoder in width and adds sequential scanning.

---
 rtl/scan_decoder_pkg.sv | 15 +
 rtl/scan_decoder_onehot.sv | 27 ++
 rtl/scan_decoder.sv | 86 ++++++++
 3 files changed

// File: rtl/scan_decoder_pkg.sv
// ============================================================================
// Module      : scan_decoder_pkg
// Description : Shared constants for the scan_decoder block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package scan_decoder_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/scan_decoder_onehot.sv
// ============================================================================
// Module      : onehot_decoder
// Description : Combinational N-to-2^N decoder with active-high enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_decoder #(
   parameter int N = 3
) (
   input  logic [N-1:0]      a,
   input  logic              e,
   output logic [(2**N)-1:0] y
);

   localparam int Y_W = 2 ** N;

   always_comb begin
      y = '0;
      if (e) begin
         y = Y_W'(1) << a;
      end
   end

endmodule

`default_nettype wire

// File: rtl/scan_decoder.sv
// ============================================================================
// Module      : scan_decoder
// Description : Registered one-hot decoder with direct-select and auto-scan
//               modes; scan dwell is programmable per step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter int N       = 3,
   parameter int DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               mode,
   input  logic               load,
   input  logic [N-1:0]       sel,
   input  logic [DWELL_W-1:0] dwell,
   output logic [(2**N)-1:0]  y,
   output logic [N-1:0]       idx,
   output logic               wrap
);

   localparam int Y_W = 2 ** N;

   logic [N-1:0]       idx_d,  idx_q;
   logic [DWELL_W-1:0] cnt_d,  cnt_q;
   logic               wrap_d, wrap_q;
   logic [Y_W-1:0]     y_d,    y_q;

   always_comb begin
      idx_d  = idx_q;
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (!en) begin
         cnt_d = '0;
      end else if (mode == MODE_DIRECT) begin
         cnt_d = '0;
         if (load) begin
            idx_d = sel;
         end
      end else begin
         // Live dwell compare: lowering dwell below cnt forces an immediate step.
         if (cnt_q >= dwell) begin
            cnt_d  = '0;
            idx_d  = idx_q + N'(1);
            wrap_d = (idx_q == {N{1'b1}});
         end else begin
            cnt_d = cnt_q + DWELL_W'(1);
         end
      end
   end

   // Decoding idx_d keeps y aligned with idx in the same cycle.
   onehot_decoder #(
      .N (N)
   ) u_onehot_decoder (
      .a (idx_d),
      .e (en),
      .y (y_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q  <= '0;
         cnt_q  <= '0;
         wrap_q <= 1'b0;
         y_q    <= '0;
      end else begin
         idx_q  <= idx_d;
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
         y_q    <= y_d;
      end
   end

   assign y    = y_q;
   assign idx  = idx_q;
   assign wrap = wrap_q;

endmodule

`default_nettype wire
